// File: rtl/block_motion_pkg.sv
// block_motion_pkg: shared types and constants for the falling-block motion sequencer.
package block_motion_pkg;

  // Sequencer states: one pass IDLE->HMOVE->VMOVE->COMMIT per frame, LOCK while landed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HMOVE  = 3'd1,
    VMOVE  = 3'd2,
    COMMIT = 3'd3,
    LOCK   = 3'd4
  } state_e;

  // Raw active-low button patterns that decode to a command.
  localparam logic [3:0] MV_LEFT  = 4'b1101;
  localparam logic [3:0] MV_RIGHT = 4'b1110;
  localparam logic [3:0] MV_DROP  = 4'b1011;
  localparam logic [3:0] MV_NONE  = 4'b1111;

  // One-hot qualified command, ordered {left, right, drop}.
  localparam logic [2:0] CMD_LEFT  = 3'b100;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_DROP  = 3'b001;
  localparam logic [2:0] CMD_NONE  = 3'b000;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/block_motion_ctrl_btn_qualify.sv
// btn_qualify: synchronizes the raw buttons, decodes them and qualifies a command
// once per frame tick. Build option HOLD_REPEAT_EN adds auto-repeat of a held
// command; without it a command fires only on the first tick after a new press.
module btn_qualify
  import block_motion_pkg::*;
`ifdef HOLD_REPEAT_EN
#(
  parameter int unsigned REPEAT_FRAMES = 32'd6
)
`endif
(
  input  logic       iRST_n,
  input  logic       iVGA_CLK,
  input  logic       ft,
  input  logic [3:0] move_ctrl,
  output logic [2:0] cmd
);

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [2:0] cur_s;
  logic [2:0] last_r;
  logic [2:0] cmd_r;
  logic       fire_s;

  // Decode the synchronized pattern; reserved and multi-press patterns mean no command.
  always_comb begin
    case (sync2_r)
      MV_LEFT:  cur_s = CMD_LEFT;
      MV_RIGHT: cur_s = CMD_RIGHT;
      MV_DROP:  cur_s = CMD_DROP;
      MV_NONE:  cur_s = CMD_NONE;
      default:  cur_s = CMD_NONE;
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 32'd1);

  logic [7:0] rep_cnt_r;
  logic [7:0] rep_nxt_s;

  // Fire on the press frame, then every REPEAT_FRAMES ticks while the same pattern is held.
  always_comb begin
    fire_s    = 1'b0;
    rep_nxt_s = rep_cnt_r;
    if (cur_s == CMD_NONE) begin
      fire_s    = 1'b0;
      rep_nxt_s = 8'd0;
    end else if (cur_s != last_r) begin
      fire_s    = 1'b1;
      rep_nxt_s = 8'd0;
    end else if (rep_cnt_r == REP_LAST) begin
      fire_s    = 1'b1;
      rep_nxt_s = 8'd0;
    end else begin
      fire_s    = 1'b0;
      rep_nxt_s = rep_cnt_r + 8'd1;
    end
  end

  // Repeat counter advances only on frame ticks.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rep_cnt_r <= 8'd0;
    end else if (ft) begin
      rep_cnt_r <= rep_nxt_s;
    end
  end
`else
  // Fire only when a valid command differs from what was seen at the previous tick.
  always_comb begin
    if ((cur_s != CMD_NONE) && (cur_s != last_r)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end
`endif

  // Two-flop synchronizer plus per-tick capture of the qualified command.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
      last_r  <= CMD_NONE;
      cmd_r   <= CMD_NONE;
    end else begin
      sync1_r <= move_ctrl;
      sync2_r <= sync1_r;
      if (ft) begin
        last_r <= cur_s;
        cmd_r  <= fire_s ? cur_s : CMD_NONE;
      end
    end
  end

  assign cmd = cmd_r;

endmodule

// File: rtl/block_motion_ctrl_chk.sv
// block_motion_chk: a frame tick must only ever be seen while the sequencer is idle.
module block_motion_chk
  import block_motion_pkg::*;
(
  input logic   iRST_n,
  input logic   iVGA_CLK,
  input logic   ft,
  input state_e state
);

  a_ft_only_in_idle: assert property (@(posedge iVGA_CLK) disable iff (!iRST_n)
    ft |-> (state == IDLE));

endmodule

// File: rtl/block_motion_ctrl.sv
// block_motion_ctrl: frame-synchronous position sequencer for the falling block.
// One position update per frame, committed three clocks after the iVS falling edge.
// Optional build macro: HOLD_REPEAT_EN (auto-repeat of held buttons).
module block_motion_ctrl
  import block_motion_pkg::*;
#(
  parameter int unsigned SCREEN_W      = 32'd640,
  parameter int unsigned SCREEN_H      = 32'd480,
  parameter int unsigned BLK_W         = 32'd20,
  parameter int unsigned BLK_H         = 32'd20,
  parameter int unsigned STEP          = 32'd4,
  parameter int unsigned FALL_FRAMES   = 32'd8,
  parameter int unsigned LOCK_FRAMES   = 32'd30,
`ifdef HOLD_REPEAT_EN
  parameter int unsigned REPEAT_FRAMES = 32'd6,
`endif
  parameter int unsigned SPAWN_X       = 32'd310,
  parameter int unsigned SPAWN_Y       = 32'd0
)
(
  input  logic       iRST_n,
  input  logic       iVGA_CLK,
  input  logic       iVS,
  input  logic [3:0] move_ctrl,
  output logic [9:0] x_axis,
  output logic [9:0] y_axis,
  output logic       oLanded,
  output logic       oFrameUpd,
  output logic       oSpawn
);

  // Comparisons run in 11 bits; results are provably below the screen size and stay 10-bit.
  localparam logic [10:0] SCR_W11   = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H11   = 11'(SCREEN_H);
  localparam logic [10:0] BLK_W11   = 11'(BLK_W);
  localparam logic [10:0] BLK_H11   = 11'(BLK_H);
  localparam logic [10:0] STEP11    = 11'(STEP);
  localparam coord_t      STEP10    = 10'(STEP);
  localparam coord_t      STEP2_10  = 10'(STEP * 32'd2);
  localparam coord_t      X_MAX10   = 10'(SCREEN_W - BLK_W);
  localparam coord_t      Y_MAX10   = 10'(SCREEN_H - BLK_H);
  localparam coord_t      SPAWN_X10 = 10'(SPAWN_X);
  localparam coord_t      SPAWN_Y10 = 10'(SPAWN_Y);
  localparam logic [7:0]  FALL_LAST = 8'(FALL_FRAMES - 32'd1);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 32'd1);

  state_e     state_r, state_nxt_s;
  logic       vs_q_r, ft_r;
  coord_t     x_r, y_r, hx_r;
  coord_t     x_nxt_s, y_nxt_s, hx_nxt_s, hx_calc_s, vy_s, fall_s;
  logic       landed_r, upd_r, spawn_r, gdue_r, lock_ph_r;
  logic       landed_nxt_s, upd_nxt_s, spawn_nxt_s, gdue_nxt_s, ph_nxt_s, vland_s;
  logic [7:0] fall_cnt_r, lock_cnt_r, fall_nxt_s, lock_nxt_s;
  logic [2:0] cmd_s;

  btn_qualify
`ifdef HOLD_REPEAT_EN
    #(.REPEAT_FRAMES(REPEAT_FRAMES))
`endif
  u_btn (
    .iRST_n    (iRST_n),
    .iVGA_CLK  (iVGA_CLK),
    .ft        (ft_r),
    .move_ctrl (move_ctrl),
    .cmd       (cmd_s)
  );

  block_motion_chk u_chk (
    .iRST_n   (iRST_n),
    .iVGA_CLK (iVGA_CLK),
    .ft       (ft_r),
    .state    (state_r)
  );

  // Frame tick: registered 1->0 edge of the vertical sync.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q_r <= 1'b1;
      ft_r   <= 1'b0;
    end else begin
      vs_q_r <= iVS;
      ft_r   <= vs_q_r & ~iVS;
    end
  end

  // Candidate horizontal and vertical positions with wall and floor clamping.
  always_comb begin
    if (cmd_s[2]) begin
      if (x_r < STEP10) begin
        hx_calc_s = 10'd0;
      end else begin
        hx_calc_s = x_r - STEP10;
      end
    end else if (cmd_s[1]) begin
      if (({1'b0, x_r} + BLK_W11 + STEP11) > SCR_W11) begin
        hx_calc_s = X_MAX10;
      end else begin
        hx_calc_s = x_r + STEP10;
      end
    end else begin
      hx_calc_s = x_r;
    end
    case ({gdue_r, cmd_s[0]})
      2'b00:   fall_s = 10'd0;
      2'b01:   fall_s = STEP10;
      2'b10:   fall_s = STEP10;
      2'b11:   fall_s = STEP2_10;
      default: fall_s = 10'd0;
    endcase
    if (({1'b0, y_r} + BLK_H11 + {1'b0, fall_s}) >= SCR_H11) begin
      vy_s    = Y_MAX10;
      vland_s = 1'b1;
    end else begin
      vy_s    = y_r + fall_s;
      vland_s = 1'b0;
    end
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_nxt_s  = state_r;
    hx_nxt_s     = hx_r;
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    landed_nxt_s = landed_r;
    upd_nxt_s    = 1'b0;
    spawn_nxt_s  = 1'b0;
    gdue_nxt_s   = gdue_r;
    fall_nxt_s   = fall_cnt_r;
    lock_nxt_s   = lock_cnt_r;
    ph_nxt_s     = lock_ph_r;
    case (state_r)
      IDLE: begin
        if (ft_r && landed_r) begin
          state_nxt_s = LOCK;
          ph_nxt_s    = 1'b0;
        end else if (ft_r) begin
          state_nxt_s = HMOVE;
          if (fall_cnt_r == FALL_LAST) begin
            gdue_nxt_s = 1'b1;
            fall_nxt_s = 8'd0;
          end else begin
            gdue_nxt_s = 1'b0;
            fall_nxt_s = fall_cnt_r + 8'd1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HMOVE: begin
        hx_nxt_s    = hx_calc_s;
        state_nxt_s = VMOVE;
      end
      VMOVE: begin
        x_nxt_s      = hx_r;
        y_nxt_s      = vy_s;
        landed_nxt_s = vland_s;
        upd_nxt_s    = 1'b1;
        state_nxt_s  = COMMIT;
      end
      COMMIT: begin
        state_nxt_s = IDLE;
      end
      LOCK: begin
        // Two cycles in LOCK so a respawn lands in the same slot as a normal commit.
        if (!lock_ph_r) begin
          ph_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          if (lock_cnt_r == LOCK_LAST) begin
            x_nxt_s      = SPAWN_X10;
            y_nxt_s      = SPAWN_Y10;
            landed_nxt_s = 1'b0;
            upd_nxt_s    = 1'b1;
            spawn_nxt_s  = 1'b1;
            lock_nxt_s   = 8'd0;
            fall_nxt_s   = 8'd0;
          end else begin
            lock_nxt_s = lock_cnt_r + 8'd1;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, position and counter registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r    <= IDLE;
      hx_r       <= SPAWN_X10;
      x_r        <= SPAWN_X10;
      y_r        <= SPAWN_Y10;
      landed_r   <= 1'b0;
      upd_r      <= 1'b0;
      spawn_r    <= 1'b0;
      gdue_r     <= 1'b0;
      fall_cnt_r <= 8'd0;
      lock_cnt_r <= 8'd0;
      lock_ph_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hx_r       <= hx_nxt_s;
      x_r        <= x_nxt_s;
      y_r        <= y_nxt_s;
      landed_r   <= landed_nxt_s;
      upd_r      <= upd_nxt_s;
      spawn_r    <= spawn_nxt_s;
      gdue_r     <= gdue_nxt_s;
      fall_cnt_r <= fall_nxt_s;
      lock_cnt_r <= lock_nxt_s;
      lock_ph_r  <= ph_nxt_s;
    end
  end

  assign x_axis    = x_r;
  assign y_axis    = y_r;
  assign oLanded   = landed_r;
  assign oFrameUpd = upd_r;
  assign oSpawn    = spawn_r;

endmodule
